// File: rtl/frame_buffer_pingpong_if.sv
// frame_buffer_pingpong_if
// Groups the camera write port, the projector read port and the handover
// status of the ping-pong frame store into one bundle.
//   master : drives wr_addr/wr_data/wr_en/wr_frame_done and
//            rd_addr/rd_en/rd_frame_start; observes the rest
//   slave  : the frame store itself; drives rd_data/rd_valid/rd_bank/
//            swap_pending/drop_count
interface frame_buffer_pingpong_if #(
  parameter int ADDR_W  = 16,
  parameter int CH_BITS = 3
);
  logic [ADDR_W-1:0]    wr_addr;
  logic [15:0]          wr_data;
  logic                 wr_en;
  logic                 wr_frame_done;
  logic [ADDR_W-1:0]    rd_addr;
  logic                 rd_en;
  logic                 rd_frame_start;
  logic [3*CH_BITS-1:0] rd_data;
  logic                 rd_valid;
  logic                 rd_bank;
  logic                 swap_pending;
  logic [7:0]           drop_count;

  modport master (
    output wr_addr, wr_data, wr_en, wr_frame_done,
    output rd_addr, rd_en, rd_frame_start,
    input  rd_data, rd_valid, rd_bank, swap_pending, drop_count
  );

  modport slave (
    input  wr_addr, wr_data, wr_en, wr_frame_done,
    input  rd_addr, rd_en, rd_frame_start,
    output rd_data, rd_valid, rd_bank, swap_pending, drop_count
  );
endinterface

// File: rtl/frame_buffer_pingpong.sv
// frame_buffer_pingpong
// Double-buffered frame store between the camera capture path and the
// projector pixel reader. Camera RGB565 pixels are cut down to CH_BITS per
// channel and written into the back bank; the reader scans the front bank.
// A completed frame only becomes the front bank at a reader frame boundary,
// so the projector never shows a torn frame.
// Ports:
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : frame_buffer_pingpong_if.slave
//              write side  wr_addr, wr_data (RGB565), wr_en, wr_frame_done
//              read side   rd_addr, rd_en, rd_frame_start -> rd_data, rd_valid
//              status      rd_bank (front bank), swap_pending, drop_count
module frame_buffer_pingpong #(
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 49152,
  parameter int CH_BITS = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  frame_buffer_pingpong_if.slave  bus
);

  localparam int W     = 3 * CH_BITS;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  typedef enum logic {
    SWAP_IDLE    = 1'b0,
    SWAP_PENDING = 1'b1
  } swap_state_t;

  logic [W-1:0] bank0 [0:DEPTH-1];
  logic [W-1:0] bank1 [0:DEPTH-1];

  swap_state_t  swap_state;
  swap_state_t  swap_state_next;
  logic         rd_bank_q;
  logic         wr_bank;
  logic         toggle;
  logic         drop_inc;
  logic [7:0]   drop_count_q;

  logic         wr_in_range;
  logic         rd_in_range;
  logic [W-1:0] wr_pixel;

  logic [W-1:0] rd_word;
  logic         rd_pend;
  logic         rd_oob;
  logic [W-1:0] rd_data_q;
  logic         rd_valid_q;

  // The writer always owns the bank the reader is not scanning.
  assign wr_bank = ~rd_bank_q;

  // Compare one bit wider so DEPTH == 2**ADDR_W does not wrap to zero.
  assign wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_L);
  assign rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_L);

  // Keep the MSBs of each channel; truncation, no rounding.
  assign wr_pixel = {bus.wr_data[15 -: CH_BITS],
                     bus.wr_data[10 -: CH_BITS],
                     bus.wr_data[4  -: CH_BITS]};

  // Pixel memory: no reset so the banks map onto block RAM and survive a
  // reset. Out-of-range writes are simply ignored.
  always_ff @(posedge clk) begin
    if (bus.wr_en && wr_in_range) begin
      if (wr_bank)
        bank1[bus.wr_addr[IDX_W-1:0]] <= wr_pixel;
      else
        bank0[bus.wr_addr[IDX_W-1:0]] <= wr_pixel;
    end
  end

  // First read stage: the RAM output register. The front bank is sampled
  // with the roles in force before this edge, so a read issued on a swap
  // edge still returns old-front data.
  always_ff @(posedge clk) begin
    if (bus.rd_en && rd_in_range)
      rd_word <= rd_bank_q ? bank1[bus.rd_addr[IDX_W-1:0]]
                           : bank0[bus.rd_addr[IDX_W-1:0]];
  end

  // Control for the first stage; cleared by reset so in-flight reads are
  // flushed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend <= 1'b0;
      rd_oob  <= 1'b0;
    end else begin
      rd_pend <= bus.rd_en;
      rd_oob  <= ~rd_in_range;
    end
  end

  // Second read stage: the output register. rd_data only moves when a
  // result is delivered and reads of out-of-range addresses return zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_pend;
      if (rd_pend)
        rd_data_q <= rd_oob ? '0 : rd_word;
    end
  end

  // Handover decision. A pending frame swaps in at the next reader frame
  // start; a frame finishing on the very cycle the reader starts swaps in
  // immediately. A second completed frame while one is pending replaces it
  // and is counted as a drop. A frame start with nothing new re-scans.
  always_comb begin
    swap_state_next = swap_state;
    toggle          = 1'b0;
    drop_inc        = 1'b0;
    case (swap_state)
      SWAP_IDLE: begin
        if (bus.rd_frame_start && bus.wr_frame_done)
          toggle = 1'b1;
        else if (bus.wr_frame_done)
          swap_state_next = SWAP_PENDING;
      end
      SWAP_PENDING: begin
        if (bus.rd_frame_start) begin
          toggle          = 1'b1;
          drop_inc        = bus.wr_frame_done;
          swap_state_next = SWAP_IDLE;
        end else if (bus.wr_frame_done) begin
          drop_inc = 1'b1;
        end
      end
      default: swap_state_next = SWAP_IDLE;
    endcase
  end

  // Handover state, front-bank select and the saturating drop counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      swap_state   <= SWAP_IDLE;
      rd_bank_q    <= 1'b0;
      drop_count_q <= 8'd0;
    end else begin
      swap_state <= swap_state_next;
      rd_bank_q  <= rd_bank_q ^ toggle;
      if (drop_inc && (drop_count_q != 8'hFF))
        drop_count_q <= drop_count_q + 8'd1;
    end
  end

  assign bus.rd_data      = rd_data_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.rd_bank      = rd_bank_q;
  assign bus.swap_pending = (swap_state == SWAP_PENDING);
  assign bus.drop_count   = drop_count_q;

endmodule

// File: tb/tb_frame_buffer_pingpong.sv
// tb_frame_buffer_pingpong
// Directed bench for the ping-pong frame store. Every driven cycle goes
// through applyStimulus, which keeps a reference model of both banks and the
// handover state and pushes expected read results onto a scoreboard queue.
// A negedge monitor pops the queue when each read is due and checks latency
// and data; status outputs are compared against the model after each step.
module tb_frame_buffer_pingpong;

  localparam int ADDR_W  = 16;
  localparam int DEPTH   = 49152;
  localparam int CH_BITS = 3;

  typedef struct {
    int         due;
    logic [8:0] data;
    bit         chk;
  } rd_exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cycle = 0;
  int   checks = 0;
  int   errors = 0;

  rd_exp_t    sb[$];
  rd_exp_t    mon_e;
  logic [8:0] mem0[int];
  logic [8:0] mem1[int];
  logic       model_front = 1'b0;
  logic       model_pend = 1'b0;
  int         model_drop = 0;

  logic [15:0] tbl_addr [5] = '{16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
  logic [15:0] tbl_pix  [5] = '{16'hFFFF, 16'hF800, 16'h07E0, 16'h001F, 16'h5555};
  logic [8:0]  tbl_exp  [5] = '{9'h1FF, 9'h1C0, 9'h038, 9'h007, 9'h0AD};

  frame_buffer_pingpong_if #(.ADDR_W(ADDR_W), .CH_BITS(CH_BITS)) bus ();

  frame_buffer_pingpong #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .CH_BITS(CH_BITS)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkStatus(input string tag);
    checkOutput({tag, "_rd_bank"}, 32'(bus.rd_bank), 32'(model_front));
    checkOutput({tag, "_swap_pending"}, 32'(bus.swap_pending), 32'(model_pend));
    checkOutput({tag, "_drop_count"}, 32'(bus.drop_count), model_drop);
  endtask

  // One clock of stimulus, driven at a negedge. The model is updated with
  // the bank roles in force before the edge, matching the DUT.
  task automatic applyStimulus(input bit we, input logic [15:0] wa,
                               input logic [15:0] wd, input logic [8:0] wexp,
                               input bit re, input logic [15:0] ra,
                               input bit d, input bit s);
    rd_exp_t e;
    bus.wr_en          = we;
    bus.wr_addr        = wa;
    bus.wr_data        = wd;
    bus.rd_en          = re;
    bus.rd_addr        = ra;
    bus.wr_frame_done  = d;
    bus.rd_frame_start = s;
    if (re) begin
      e.due  = cycle + 2;
      e.data = 9'h000;
      e.chk  = 1'b1;
      if (int'(ra) < DEPTH) begin
        if (model_front == 1'b0 && mem0.exists(int'(ra)))      e.data = mem0[int'(ra)];
        else if (model_front == 1'b1 && mem1.exists(int'(ra))) e.data = mem1[int'(ra)];
        else                                                    e.chk  = 1'b0;
      end
      sb.push_back(e);
    end
    if (we && int'(wa) < DEPTH) begin
      if (model_front) mem0[int'(wa)] = wexp;
      else             mem1[int'(wa)] = wexp;
    end
    if (s && (model_pend || d)) begin
      if (d && model_pend && model_drop < 255) model_drop++;
      model_front = ~model_front;
      model_pend  = 1'b0;
    end else if (!s && d) begin
      if (model_pend && model_drop < 255) model_drop++;
      model_pend = 1'b1;
    end
    @(negedge clk);
    bus.wr_en          = 1'b0;
    bus.rd_en          = 1'b0;
    bus.wr_frame_done  = 1'b0;
    bus.rd_frame_start = 1'b0;
  endtask

  // Read scoreboard: each expected result must appear exactly on its due
  // cycle, and no result may appear without one being due.
  always @(negedge clk) begin
    if (reset_n) begin
      if (sb.size() != 0 && sb[0].due == cycle) begin
        mon_e = sb.pop_front();
        checkOutput("rd_valid_due", 32'(bus.rd_valid), 32'd1);
        if (mon_e.chk) checkOutput("rd_data", 32'(bus.rd_data), 32'(mon_e.data));
      end else if (bus.rd_valid !== 1'b0) begin
        checkOutput("rd_valid_spurious", 32'(bus.rd_valid), 32'd0);
      end
    end
  end

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_frame_done = 1'b0;
    bus.rd_en = 1'b0; bus.rd_addr = '0; bus.rd_frame_start = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    checkStatus("reset");
    checkOutput("reset_rd_valid", 32'(bus.rd_valid), 32'd0);
    checkOutput("reset_rd_data", 32'(bus.rd_data), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Read latency from an unwritten front bank
    applyStimulus(0, 0, 0, 0, 1, 16'd3, 0, 0);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    // Fill the back bank, hand it over and read it back to back
    for (int i = 0; i < 5; i++)
      applyStimulus(1, tbl_addr[i], tbl_pix[i], tbl_exp[i], 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    checkStatus("after_done");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    checkStatus("after_start");
    for (int i = 0; i < 5; i++)
      applyStimulus(0, 0, 0, 0, 1, tbl_addr[i], 0, 0);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    // New content in the other bank
    applyStimulus(1, 16'd5, 16'h001F, 9'h007, 0, 0, 0, 0);
    applyStimulus(1, 16'd6, 16'h07E0, 9'h038, 0, 0, 0, 0);

    // Two completions without a frame start: one drop
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    checkStatus("double_done");
    // Frame start with a read on the same edge: read sees the old front
    applyStimulus(0, 0, 0, 0, 1, 16'd5, 0, 1);
    checkStatus("pending_swap");
    applyStimulus(0, 0, 0, 0, 1, 16'd5, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 16'd6, 0, 0);
    // Frame start with nothing pending: re-scan, no change
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    checkStatus("rescan");

    // Simultaneous done/start with and without a pending frame
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    checkStatus("immediate_swap");
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    checkStatus("swap_with_drop");

    // Out-of-range writes and reads
    applyStimulus(1, 16'(DEPTH), 16'h0000, 9'h000, 0, 0, 0, 0);
    applyStimulus(1, 16'(DEPTH + 5), 16'h0000, 9'h000, 0, 0, 0, 0);
    applyStimulus(1, 16'hFFFF, 16'h0000, 9'h000, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    checkStatus("oob_swap");
    for (int i = 0; i < 5; i++)
      applyStimulus(0, 0, 0, 0, 1, tbl_addr[i], 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 16'(DEPTH), 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 16'hFFFF, 0, 0);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    // Drive the drop counter into saturation
    while (model_drop < 254) applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    checkStatus("drop_254");
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    checkStatus("drop_255");
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    checkStatus("drop_sat");

    // Reset in the middle of a read burst
    applyStimulus(0, 0, 0, 0, 1, 16'd5, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 16'd6, 0, 0);
    bus.rd_en   = 1'b1;
    bus.rd_addr = 16'd7;
    @(posedge clk);
    #1;
    checkOutput("pre_reset_rd_valid", 32'(bus.rd_valid), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    sb.delete();
    model_front = 1'b0;
    model_pend  = 1'b0;
    model_drop  = 0;
    checkOutput("midreset_rd_valid", 32'(bus.rd_valid), 32'd0);
    checkOutput("midreset_rd_data", 32'(bus.rd_data), 32'd0);
    checkStatus("midreset");
    bus.rd_en = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_rd_valid", 32'(bus.rd_valid), 32'd0);

    // Memory survives reset
    applyStimulus(0, 0, 0, 0, 1, 16'd5, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 16'd6, 0, 0);

    // Let the scoreboard drain within a bounded number of cycles
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
